// File: rtl/wasm_operand_stack.sv
// rtl/wasm_operand_stack.sv - typed WebAssembly operand stack with i32/i64 binary-op engine
// Top of stack lives in registers; lower entries sit in a synchronous-read array.
module wasm_operand_stack #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op,
  input  logic [63:0]           in_value,
  input  logic [1:0]            in_type,
  output logic [63:0]           result,
  output logic [1:0]            result_type,
  output logic                  result_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [3:0]            trap
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] TWO  = (DEPTH_LOG2 + 1)'(2);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  localparam logic [3:0] TRAP_NONE     = 4'd0;
  localparam logic [3:0] TRAP_OVERFLOW = 4'd1;
  localparam logic [3:0] TRAP_UNDER    = 4'd2;
  localparam logic [3:0] TRAP_TYPE     = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t                 state;
  logic [2:0]             pend_op;
  logic [65:0]            mem [0:DEPTH-1];
  logic [65:0]            rd_q;
  logic                   accept;
  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic [DEPTH_LOG2-1:0]  rd_addr;
  logic [63:0]            a_val;
  logic [1:0]             a_type;
  logic [63:0]            alu_raw;
  logic [63:0]            alu_res;
  logic                   types_ok;

  always_comb begin
    accept  = op_valid && op_ready && (state == IDLE);
    wr_en   = accept && (trap == TRAP_NONE) && (op == OP_PUSH) &&
              (count != '0) && (count != FULL);
    wr_addr = DEPTH_LOG2'(count - 1'b1);
    rd_addr = DEPTH_LOG2'(count - TWO);
  end

  // Entries are stored as {type, value}; the read port only fires in FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {result_type, result};
    end
    if (state == FETCH) begin
      rd_q <= mem[rd_addr];
    end
  end

  always_comb begin
    a_val  = rd_q[63:0];
    a_type = rd_q[65:64];
    case (pend_op)
      OP_ADD:  alu_raw = a_val + result;
      OP_SUB:  alu_raw = a_val - result;
      OP_AND:  alu_raw = a_val & result;
      OP_OR:   alu_raw = a_val | result;
      OP_XOR:  alu_raw = a_val ^ result;
      default: alu_raw = a_val;
    endcase
    // Low 32 bits of every op are independent of the upper halves, so i32 just masks.
    alu_res  = (a_type == 2'd0) ? {32'b0, alu_raw[31:0]} : alu_raw;
    types_ok = (a_type == result_type) && !result_type[1];
  end

  assign result_empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_ready    <= 1'b1;
      result      <= '0;
      result_type <= '0;
      count       <= '0;
      trap        <= TRAP_NONE;
      pend_op     <= OP_NOP;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (trap == TRAP_NONE)) begin
            case (op)
              OP_NOP: ;
              OP_PUSH: begin
                if (count == FULL) begin
                  trap <= TRAP_OVERFLOW;
                end else begin
                  result      <= in_value;
                  result_type <= in_type;
                  count       <= count + 1'b1;
                end
              end
              default: begin
                if (((op == OP_DROP) && (count == '0)) ||
                    ((op != OP_DROP) && (count < TWO))) begin
                  trap <= TRAP_UNDER;
                end else begin
                  pend_op  <= op;
                  state    <= FETCH;
                  op_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          state    <= IDLE;
          op_ready <= 1'b1;
          if (pend_op == OP_DROP) begin
            count <= count - 1'b1;
            if (count == (DEPTH_LOG2 + 1)'(1)) begin
              result      <= '0;
              result_type <= '0;
            end else begin
              result      <= rd_q[63:0];
              result_type <= rd_q[65:64];
            end
          end else if (!types_ok) begin
            trap <= TRAP_TYPE;
          end else begin
            result      <= alu_res;
            result_type <= a_type;
            count       <= count - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_operand_stack.sv
// tb/tb_wasm_operand_stack.sv - scoreboard bench for wasm_operand_stack
module tb_wasm_operand_stack;

  localparam int DL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = 3'd0;
  logic [63:0] in_value = '0;
  logic [1:0]  in_type = '0;
  logic [63:0] result;
  logic [1:0]  result_type;
  logic        result_empty;
  logic [DL:0] count;
  logic [3:0]  trap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] r;
    logic [1:0]  t;
    logic [DL:0] c;
    logic [3:0]  tr;
  } exp_t;

  exp_t sb[$];

  wasm_operand_stack #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .in_value(in_value), .in_type(in_type), .result(result),
    .result_type(result_type), .result_empty(result_empty), .count(count),
    .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Push the expected outcome, drive one command, pop and compare on completion.
  task automatic send(input string name, input logic [2:0] o, input logic [63:0] v,
                      input logic [1:0] ty, input logic [63:0] er, input logic [1:0] et,
                      input logic [DL:0] ec, input logic [3:0] etr);
    exp_t e;
    int   n;
    sb.push_back('{er, et, ec, etr});
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    op_valid = 1'b1;
    op       = o;
    in_value = v;
    in_type  = ty;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op       = 3'd0;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: op_ready=%b expected 1", name, op_ready);
    end
    checks++;
    if (result !== e.r) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, e.r);
    end
    checks++;
    if (result_type !== e.t) begin
      errors++;
      $display("FAIL %s result_type: got %0d expected %0d", name, result_type, e.t);
    end
    checks++;
    if (count !== e.c) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, count, e.c);
    end
    checks++;
    if (result_empty !== (e.c == '0)) begin
      errors++;
      $display("FAIL %s result_empty: got %b expected %b", name, result_empty, (e.c == '0));
    end
    checks++;
    if (trap !== e.tr) begin
      errors++;
      $display("FAIL %s trap: got %0d expected %0d", name, trap, e.tr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({op_ready, result_empty} !== 2'b11 || result !== 64'd0 || result_type !== 2'd0 ||
        count !== '0 || trap !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b empty=%b result=%h type=%0d count=%0d trap=%0d expected 1 1 0 0 0 0",
               op_ready, result_empty, result, result_type, count, trap);
    end
  endtask

  task automatic test_add();
    do_reset();
    send("add_push1", 3'd1, 64'd1, 2'd0, 64'd1, 2'd0, 3'd1, 4'd0);
    send("add_push2", 3'd1, 64'd2, 2'd0, 64'd2, 2'd0, 3'd2, 4'd0);
    send("add_exec",  3'd3, 64'd0, 2'd0, 64'd3, 2'd0, 3'd1, 4'd0);
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    send("lat_push3", 3'd1, 64'd3, 2'd0, 64'd3, 2'd0, 3'd1, 4'd0);
    send("lat_push4", 3'd1, 64'd4, 2'd0, 64'd4, 2'd0, 3'd2, 4'd0);
    op_valid = 1'b1;
    op       = 3'd3;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op       = 3'd0;
    n = 0;
    while (!op_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL binop_latency: busy cycles %0d expected 2", n);
    end
    checks++;
    if (result !== 64'd7) begin
      errors++;
      $display("FAIL latency_result: got %h expected 7", result);
    end
  endtask

  task automatic test_i32_wrap();
    do_reset();
    send("wrap_pushff", 3'd1, 64'hFFFF_FFFF, 2'd0, 64'hFFFF_FFFF, 2'd0, 3'd1, 4'd0);
    send("wrap_push1",  3'd1, 64'd1, 2'd0, 64'd1, 2'd0, 3'd2, 4'd0);
    send("wrap_add",    3'd3, 64'd0, 2'd0, 64'd0, 2'd0, 3'd1, 4'd0);
    send("zx_pushdead", 3'd1, 64'hDEAD_0000_0000_0005, 2'd0, 64'hDEAD_0000_0000_0005, 2'd0, 3'd2, 4'd0);
    send("zx_push3",    3'd1, 64'd3, 2'd0, 64'd3, 2'd0, 3'd3, 4'd0);
    send("zx_xor",      3'd7, 64'd0, 2'd0, 64'd6, 2'd0, 3'd2, 4'd0);
  endtask

  task automatic test_i64_sub();
    do_reset();
    send("sub_push5", 3'd1, 64'd5, 2'd1, 64'd5, 2'd1, 3'd1, 4'd0);
    send("sub_push7", 3'd1, 64'd7, 2'd1, 64'd7, 2'd1, 3'd2, 4'd0);
    send("sub_exec",  3'd4, 64'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd1, 3'd1, 4'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send("b2b_pushf0", 3'd1, 64'hF0, 2'd1, 64'hF0, 2'd1, 3'd1, 4'd0);
    send("b2b_push3c", 3'd1, 64'h3C, 2'd1, 64'h3C, 2'd1, 3'd2, 4'd0);
    send("b2b_and",    3'd5, 64'd0, 2'd0, 64'h30, 2'd1, 3'd1, 4'd0);
    send("b2b_push0f", 3'd1, 64'h0F, 2'd1, 64'h0F, 2'd1, 3'd2, 4'd0);
    send("b2b_or",     3'd6, 64'd0, 2'd0, 64'h3F, 2'd1, 3'd1, 4'd0);
    send("b2b_nop",    3'd0, 64'd5, 2'd0, 64'h3F, 2'd1, 3'd1, 4'd0);
  endtask

  task automatic test_drop();
    do_reset();
    send("drop_push10", 3'd1, 64'd10, 2'd0, 64'd10, 2'd0, 3'd1, 4'd0);
    send("drop_push20", 3'd1, 64'd20, 2'd1, 64'd20, 2'd1, 3'd2, 4'd0);
    send("drop_one",    3'd2, 64'd0, 2'd0, 64'd10, 2'd0, 3'd1, 4'd0);
    send("drop_last",   3'd2, 64'd0, 2'd0, 64'd0, 2'd0, 3'd0, 4'd0);
  endtask

  task automatic test_mismatch();
    do_reset();
    send("mm_push_i32", 3'd1, 64'd1, 2'd0, 64'd1, 2'd0, 3'd1, 4'd0);
    send("mm_push_i64", 3'd1, 64'd1, 2'd1, 64'd1, 2'd1, 3'd2, 4'd0);
    send("mm_add",      3'd3, 64'd0, 2'd0, 64'd1, 2'd1, 3'd2, 4'd3);
    send("mm_sticky",   3'd1, 64'd7, 2'd0, 64'd1, 2'd1, 3'd2, 4'd3);
  endtask

  task automatic test_capacity();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send("cap_push", 3'd1, 64'(11 + i), 2'd0, 64'(11 + i), 2'd0, 3'(i + 1), 4'd0);
    end
    send("cap_overflow", 3'd1, 64'd99, 2'd0, 64'd14, 2'd0, 3'd4, 4'd1);
    send("cap_first_wins", 3'd2, 64'd0, 2'd0, 64'd14, 2'd0, 3'd4, 4'd1);
  endtask

  task automatic test_underflow();
    do_reset();
    send("uf_drop_empty", 3'd2, 64'd0, 2'd0, 64'd0, 2'd0, 3'd0, 4'd2);
    do_reset();
    send("uf_push4", 3'd1, 64'd4, 2'd0, 64'd4, 2'd0, 3'd1, 4'd0);
    op_valid = 1'b1;
    op       = 3'd3;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op       = 3'd0;
    checks++;
    if (op_ready !== 1'b1 || trap !== 4'd2 || count !== 3'd1 || result !== 64'd4) begin
      errors++;
      $display("FAIL uf_add_count1: ready=%b trap=%0d count=%0d result=%h expected 1 2 1 4",
               op_ready, trap, count, result);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    send("rst_push1", 3'd1, 64'd1, 2'd0, 64'd1, 2'd0, 3'd1, 4'd0);
    send("rst_push2", 3'd1, 64'd2, 2'd0, 64'd2, 2'd0, 3'd2, 4'd0);
    op_valid = 1'b1;
    op       = 3'd3;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op       = 3'd0;
    reset    = 1'b0;
    #1;
    checks++;
    if ({op_ready, result_empty} !== 2'b11 || result !== 64'd0 || result_type !== 2'd0 ||
        count !== '0 || trap !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_op: ready=%b empty=%b result=%h type=%0d count=%0d trap=%0d expected 1 1 0 0 0 0",
               op_ready, result_empty, result, result_type, count, trap);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send("rst_push9", 3'd1, 64'd9, 2'd0, 64'd9, 2'd0, 3'd1, 4'd0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_latency();
    test_i32_wrap();
    test_i64_sub();
    test_back_to_back();
    test_drop();
    test_mismatch();
    test_capacity();
    test_underflow();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
